// File: rtl/anc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anc_pkg
// Description : Shared types and defaults for the ANC sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package anc_pkg;

    localparam int C_NTAPS_DEFAULT = 32;
    localparam int C_AW_DEFAULT    = 6;

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_WAIT = 3'd1;
    localparam logic [2:0] C_ST_CAP  = 3'd2;
    localparam logic [2:0] C_ST_FIR  = 3'd3;
    localparam logic [2:0] C_ST_OUT  = 3'd4;
    localparam logic [2:0] C_ST_LMS  = 3'd5;
    localparam logic [2:0] C_ST_INJ  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = C_ST_IDLE,
        S_WAIT = C_ST_WAIT,
        S_CAP  = C_ST_CAP,
        S_FIR  = C_ST_FIR,
        S_OUT  = C_ST_OUT,
        S_LMS  = C_ST_LMS,
        S_INJ  = C_ST_INJ
    } anc_state_t;

endpackage
`default_nettype wire

// File: rtl/anc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : anc_seq_ctrl_if
// Description : Sample handshake, weight-injection and datapath strobe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface anc_seq_ctrl_if #(
    parameter int AW = anc_pkg::C_AW_DEFAULT
);
    logic          init_done;
    logic          bypass_mode_sel;
    logic          in_valid;
    logic          controller_ready;
    logic          bypass_ready;
    logic          sample_ld;
    logic [AW-1:0] tap_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          wt_we;
    logic          wt_src_inj;
    logic          out_valid;
    logic          fir_act;
    logic          overrun;

    // Controller side
    modport master (
        input  init_done, bypass_mode_sel, in_valid, bypass_ready,
        output controller_ready, sample_ld, tap_addr, mac_clr, mac_en,
               wt_we, wt_src_inj, out_valid, fir_act, overrun
    );

    // Datapath / source side
    modport slave (
        output init_done, bypass_mode_sel, in_valid, bypass_ready,
        input  controller_ready, sample_ld, tap_addr, mac_clr, mac_en,
               wt_we, wt_src_inj, out_valid, fir_act, overrun
    );

endinterface
`default_nettype wire

// File: rtl/anc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : anc_seq_ctrl
// Description : Per-sample FIR/LMS sequencer with FPGA weight-injection bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module anc_seq_ctrl
    import anc_pkg::*;
#(
    parameter int NTAPS = C_NTAPS_DEFAULT,
    parameter int AW    = C_AW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    anc_seq_ctrl_if.master bus
);

    localparam logic [AW-1:0] C_LAST_TAP = AW'(NTAPS - 1);

    anc_state_t    r_state;
    anc_state_t    w_state_nxt;
    logic [AW-1:0] r_tap;
    logic [AW-1:0] w_tap_nxt;
    logic          r_overrun;

    logic          w_sample_ld;
    logic [AW-1:0] w_tap_addr;
    logic          w_mac_clr;
    logic          w_mac_en;
    logic          w_wt_we;
    logic          w_wt_src_inj;
    logic          w_out_valid;
    logic          w_fir_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tap     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tap   <= w_tap_nxt;
            // A sample arriving while the result is still being presented means
            // the upstream rate exceeds one sample per processing window.
            if (r_state == S_OUT && bus.in_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tap_nxt    = '0;
        w_sample_ld  = 1'b0;
        w_tap_addr   = r_tap;
        w_mac_clr    = 1'b0;
        w_mac_en     = 1'b0;
        w_wt_we      = 1'b0;
        w_wt_src_inj = 1'b0;
        w_out_valid  = 1'b0;
        w_fir_act    = 1'b0;

        case (r_state)
            S_IDLE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                w_sample_ld = 1'b1;
                w_state_nxt = S_FIR;
            end
            S_FIR: begin
                w_fir_act = 1'b1;
                w_mac_clr = (r_tap == '0);
                w_mac_en  = (r_tap != '0);
                if (r_tap == C_LAST_TAP) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_tap_nxt = r_tap + AW'(1);
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                w_state_nxt = bus.bypass_mode_sel ? S_INJ : S_LMS;
            end
            S_LMS: begin
                w_wt_we = 1'b1;
                if (r_tap == C_LAST_TAP) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_tap_nxt = r_tap + AW'(1);
                end
            end
            S_INJ: begin
                // Address only advances on an accepted injected weight
                w_wt_src_inj = 1'b1;
                w_wt_we      = bus.bypass_ready;
                w_tap_nxt    = r_tap;
                if (bus.bypass_ready) begin
                    if (r_tap == C_LAST_TAP) begin
                        w_state_nxt = S_WAIT;
                        w_tap_nxt   = '0;
                    end else begin
                        w_tap_nxt = r_tap + AW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Losing configuration aborts everything and silences the datapath at once
        if (!bus.init_done) begin
            w_state_nxt  = S_IDLE;
            w_tap_nxt    = '0;
            w_sample_ld  = 1'b0;
            w_tap_addr   = '0;
            w_mac_clr    = 1'b0;
            w_mac_en     = 1'b0;
            w_wt_we      = 1'b0;
            w_wt_src_inj = 1'b0;
            w_out_valid  = 1'b0;
            w_fir_act    = 1'b0;
        end
    end

    assign bus.controller_ready = (r_state == S_WAIT);
    assign bus.sample_ld        = w_sample_ld;
    assign bus.tap_addr         = w_tap_addr;
    assign bus.mac_clr          = w_mac_clr;
    assign bus.mac_en           = w_mac_en;
    assign bus.wt_we            = w_wt_we;
    assign bus.wt_src_inj       = w_wt_src_inj;
    assign bus.out_valid        = w_out_valid;
    assign bus.fir_act          = w_fir_act;
    assign bus.overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_anc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_anc_seq_ctrl
// Description : Directed + randomized bench for anc_seq_ctrl against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anc_seq_ctrl;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    anc_seq_ctrl_if #(.AW(6)) bus ();
    anc_seq_ctrl_if #(.AW(1)) bus2 ();

    anc_seq_ctrl #(.NTAPS(N), .AW(6)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    anc_seq_ctrl #(.NTAPS(2), .AW(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Timeline model: phase 0 = idle, 1 = ready for a sample, 2 = busy.
    // t counts cycles since the handshake; inj phase counts accepted weights.
    int m_ph = 0, m_t = 0, m_w = 0;
    bit m_inj = 0, m_ovr = 0;

    int hs_cyc = -1, ov_cyc = -1, ov_prev = -1, rise_cyc = -1;
    int n_ov = 0, n_inj_we = 0, n_lms_we = 0, last_inj_tap = -1;
    bit prev_ready = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"},     8'(bus.controller_ready), 8'd0);
        chk({tag, "_sample_ld"}, 8'(bus.sample_ld),        8'd0);
        chk({tag, "_tap_addr"},  8'(bus.tap_addr),         8'd0);
        chk({tag, "_mac_clr"},   8'(bus.mac_clr),          8'd0);
        chk({tag, "_mac_en"},    8'(bus.mac_en),           8'd0);
        chk({tag, "_wt_we"},     8'(bus.wt_we),            8'd0);
        chk({tag, "_src_inj"},   8'(bus.wt_src_inj),       8'd0);
        chk({tag, "_out_valid"}, 8'(bus.out_valid),        8'd0);
        chk({tag, "_fir_act"},   8'(bus.fir_act),          8'd0);
        chk({tag, "_overrun"},   8'(bus.overrun),          8'd0);
    endtask

    task automatic model_reset();
        m_ph  = 0;
        m_t   = 0;
        m_w   = 0;
        m_inj = 0;
        m_ovr = 0;
    endtask

    task automatic cycle();
        logic e_ld, e_clr, e_en, e_we, e_src, e_ov, e_fir;
        logic [7:0] e_tap;
        @(negedge clk);
        {e_ld, e_clr, e_en, e_we, e_src, e_ov, e_fir} = '0;
        e_tap = 8'd0;
        if (bus.init_done && m_ph == 2) begin
            if (m_t == 1) begin
                e_ld = 1'b1;
            end else if (m_t <= N + 1) begin
                e_fir = 1'b1;
                e_tap = 8'(m_t - 2);
                e_clr = (m_t == 2);
                e_en  = (m_t > 2);
            end else if (m_t == N + 2) begin
                e_ov = 1'b1;
            end else if (!m_inj) begin
                e_we  = 1'b1;
                e_tap = 8'(m_t - N - 3);
            end else begin
                e_src = 1'b1;
                e_we  = bus.bypass_ready;
                e_tap = 8'(m_w);
            end
        end
        chk("ready",      8'(bus.controller_ready), 8'(m_ph == 1));
        chk("sample_ld",  8'(bus.sample_ld),  8'(e_ld));
        chk("mac_clr",    8'(bus.mac_clr),    8'(e_clr));
        chk("mac_en",     8'(bus.mac_en),     8'(e_en));
        chk("wt_we",      8'(bus.wt_we),      8'(e_we));
        chk("wt_src_inj", 8'(bus.wt_src_inj), 8'(e_src));
        chk("out_valid",  8'(bus.out_valid),  8'(e_ov));
        chk("fir_act",    8'(bus.fir_act),    8'(e_fir));
        chk("tap_addr",   8'(bus.tap_addr),   e_tap);
        chk("overrun",    8'(bus.overrun),    8'(m_ovr));

        if (bus.in_valid && bus.controller_ready && bus.init_done) hs_cyc = cyc;
        if (bus.out_valid) begin
            ov_prev = ov_cyc;
            ov_cyc  = cyc;
            n_ov++;
        end
        if (bus.wt_we && bus.wt_src_inj) begin
            n_inj_we++;
            last_inj_tap = int'(bus.tap_addr);
        end
        if (bus.wt_we && !bus.wt_src_inj) n_lms_we++;
        if (bus.controller_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = bus.controller_ready;

        @(posedge clk);
        if (m_ph == 2 && m_t == N + 2 && bus.in_valid) m_ovr = 1;
        if (!bus.init_done) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: m_ph = 1;
                1: if (bus.in_valid) begin
                       m_ph = 2;
                       m_t  = 1;
                       m_w  = 0;
                   end
                default: begin
                    if (m_t == N + 2) m_inj = bus.bypass_mode_sel;
                    if (m_t > N + 2 && m_inj) begin
                        if (bus.bypass_ready) begin
                            m_w++;
                            if (m_w == N) m_ph = 1;
                        end
                    end else if (m_t == 2 * N + 2) begin
                        m_ph = 1;
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic handshake();
        bit got = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            if (bus.controller_ready) got = 1;
            cycle();
        end
        bus.in_valid = 1'b0;
        if (!got) chk("handshake_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.init_done = 0;  bus.bypass_mode_sel = 0;  bus.in_valid = 0;  bus.bypass_ready = 0;
        bus2.init_done = 0; bus2.bypass_mode_sel = 0; bus2.in_valid = 0; bus2.bypass_ready = 0;
        model_reset();
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Not configured: requests are ignored
        bus.in_valid = 1'b1;
        repeat (5) cycle();
        bus.in_valid = 1'b0;

        // Single sample, LMS path, latency checks
        bus.init_done = 1'b1;
        repeat (9) cycle();
        n_lms_we = 0;
        handshake();
        repeat (75) cycle();
        chk("lat_out_valid", 8'(ov_cyc - hs_cyc), 8'(N + 2));
        chk("lat_ready",     8'(rise_cyc - hs_cyc), 8'(2 * N + 3));
        chk("lms_writes",    8'(n_lms_we), 8'(N));

        // Injection path, weight on every third cycle
        bus.bypass_mode_sel = 1'b1;
        n_inj_we = 0;
        handshake();
        repeat (200) begin
            bus.bypass_ready = (cyc % 3 == 0);
            cycle();
        end
        bus.bypass_ready    = 1'b0;
        bus.bypass_mode_sel = 1'b0;
        chk("inj_writes",   8'(n_inj_we), 8'(N));
        chk("inj_last_tap", 8'(last_inj_tap), 8'(N - 1));
        chk("inj_back_wait", 8'(bus.controller_ready), 8'd1);

        // Continuous requests: overrun and steady-state throughput
        n_ov = 0;
        bus.in_valid = 1'b1;
        repeat (4 * (2 * N + 3) + 5) cycle();
        bus.in_valid = 1'b0;
        chk("stream_period",  8'(ov_cyc - ov_prev), 8'(2 * N + 3));
        chk("stream_count",   8'(n_ov), 8'd4);
        chk("stream_overrun", 8'(bus.overrun), 8'd1);
        repeat (70) cycle();

        // Asynchronous reset in the middle of FIR
        handshake();
        repeat (16) cycle();
        chk("fir_tap15", 8'(bus.tap_addr), 8'd15);
        #1 rst_n = 1'b0;
        #1 check_zero("rst_fir");
        model_reset();
        #1 rst_n = 1'b1;
        n_ov = 0;
        repeat (50) cycle();
        chk("no_ov_after_rst", 8'(n_ov), 8'd0);
        handshake();
        repeat (70) cycle();
        chk("ov_after_rst", 8'(n_ov), 8'd1);

        // Configuration lost during LMS
        handshake();
        repeat (N + 10) cycle();
        bus.init_done = 1'b0;
        repeat (6) cycle();
        chk("ready_init_low", 8'(bus.controller_ready), 8'd0);
        bus.init_done = 1'b1;
        repeat (3) cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid        = ($urandom_range(0, 3) == 0);
            bus.bypass_mode_sel = 1'($urandom_range(0, 1));
            bus.bypass_ready    = 1'($urandom_range(0, 1));
            bus.init_done       = ($urandom_range(0, 299) != 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.init_done = 1'b0;

        // Minimum tap count instance
        bus2.init_done = 1'b1;
        @(posedge clk); #1;
        chk("n2_ready", 8'(bus2.controller_ready), 8'd1);
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("n2_sample_ld", 8'(bus2.sample_ld), 8'(k == 1));
            chk("n2_mac_clr",   8'(bus2.mac_clr),   8'(k == 2));
            chk("n2_out_valid", 8'(bus2.out_valid), 8'(k == 4));
            chk("n2_wt_we",     8'(bus2.wt_we),     8'(k == 5 || k == 6));
            chk("n2_tap_addr",  8'(bus2.tap_addr),  8'(k == 3 || k == 6));
            chk("n2_ready_k",   8'(bus2.controller_ready), 8'(k == 7));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
